// File: rtl/player_motion.sv
// Keycode-driven player sprite motion: VS-derived frame tick, horizontal step, gravity jump FSM.
// Define PLAYER_WRAP_EN to make horizontal motion wrap at the screen edges instead of clamping.
module player_motion #(
  parameter int COORD_W  = 10,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int SIZE     = 16,
  parameter int STEP_X   = 2,
  parameter int JUMP_V   = 12,
  parameter int GRAVITY  = 1,
  parameter int VMAX     = 15,
  parameter int GROUND_Y = 464,
  parameter int START_X  = 312
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_vs,
  input  logic [7:0]         keycode,
  output logic [COORD_W-1:0] PlayerX,
  output logic [COORD_W-1:0] PlayerY,
  output logic [COORD_W-1:0] PlayerS,
  output logic               Facing,
  output logic               Airborne,
  output logic               frame_tick
);

  localparam int VW = COORD_W + 2;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_JUMP  = 8'h1A;

  localparam int X_MAX = SCREEN_W - SIZE;

  localparam logic [COORD_W-1:0] X_MAX_C   = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] STEP_C    = COORD_W'(STEP_X);
  localparam logic [COORD_W-1:0] START_C   = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] GROUND_C  = COORD_W'(GROUND_Y);

  localparam logic signed [VW-1:0] JUMP_S   = VW'(JUMP_V);
  localparam logic signed [VW-1:0] GRAV_S   = VW'(GRAVITY);
  localparam logic signed [VW-1:0] VMAX_S   = VW'(VMAX);
  localparam logic signed [VW-1:0] GROUND_S = VW'(GROUND_Y);

  typedef enum logic [1:0] {
    GROUND,
    RISE,
    FALL
  } vstate_e;

  logic                  s1_q, s2_q, s3_q;
  logic                  tick;
  logic [COORD_W-1:0]    x_q, x_d;
  logic [COORD_W-1:0]    y_q;
  logic                  facing_q, facing_d;
  logic signed [VW-1:0]  vy_q;
  logic signed [VW-1:0]  y_s, yn, vyn, vyn_cap;
  vstate_e               st_q;

  assign tick = s2_q & ~s3_q;

  // Horizontal next position; edge handling selected at build time.
  always_comb begin
    x_d      = x_q;
    facing_d = facing_q;
    if (keycode == KEY_LEFT) begin
      facing_d = 1'b0;
      if (int'(x_q) < STEP_X) begin
`ifdef PLAYER_WRAP_EN
        x_d = X_MAX_C;
`else
        x_d = '0;
`endif
      end else begin
        x_d = x_q - STEP_C;
      end
    end else if (keycode == KEY_RIGHT) begin
      facing_d = 1'b1;
      if (int'(x_q) + STEP_X > X_MAX) begin
`ifdef PLAYER_WRAP_EN
        x_d = '0;
`else
        x_d = X_MAX_C;
`endif
      end else begin
        x_d = x_q + STEP_C;
      end
    end
  end

  // Signed vertical arithmetic shared by RISE and FALL.
  always_comb begin
    y_s     = signed'({2'b00, y_q});
    yn      = y_s + vy_q;
    vyn     = vy_q + GRAV_S;
    vyn_cap = (vyn > VMAX_S) ? VMAX_S : vyn;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      x_q      <= START_C;
      y_q      <= GROUND_C;
      vy_q     <= '0;
      facing_q <= 1'b1;
      st_q     <= GROUND;
    end else begin
      s1_q <= frame_vs;
      s2_q <= s1_q;
      s3_q <= s2_q;
      if (tick) begin
        x_q      <= x_d;
        facing_q <= facing_d;
        case (st_q)
          GROUND: begin
            y_q  <= GROUND_C;
            vy_q <= '0;
            if (keycode == KEY_JUMP) begin
              vy_q <= -JUMP_S;
              st_q <= RISE;
            end
          end
          RISE: begin
            if (yn < 0) begin
              y_q  <= '0;
              vy_q <= '0;
              st_q <= FALL;
            end else begin
              y_q  <= yn[COORD_W-1:0];
              vy_q <= vyn;
              if (vyn >= 0) st_q <= FALL;
            end
          end
          FALL: begin
            if (yn >= GROUND_S) begin
              y_q  <= GROUND_C;
              vy_q <= '0;
              st_q <= GROUND;
            end else begin
              y_q  <= yn[COORD_W-1:0];
              vy_q <= vyn_cap;
            end
          end
          default: begin
            y_q  <= GROUND_C;
            vy_q <= '0;
            st_q <= GROUND;
          end
        endcase
      end
    end
  end

  assign PlayerX    = x_q;
  assign PlayerY    = y_q;
  assign PlayerS    = COORD_W'(SIZE);
  assign Facing     = facing_q;
  assign Airborne   = (st_q != GROUND);
  assign frame_tick = tick;

endmodule
